pool_window_gen: RTL and testbench

Upstream feeder for `max_pooling`. It accepts a row-major stream of fixed-point activations (IL.FL format) for a ROWS×COLS feature map. It buffers one even row in a line buffer and assembles non-overlapping 2×2, stride-2 windows. Each completed window is presented as the four-element `win` array, with a one-cycle `win_ready` pulse that drives `max_pooling.input_ready`.

---
 rtl/pool_pkg.sv | 17 +
 rtl/pool_line_buffer.sv | 37 +++
 rtl/pool_window_gen.sv | 118 +++++++++++
 tb/tb_pool_window_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling datapath: fixed-point format and
// window element ordering used by pool_window_gen and max_pooling.
package pool_pkg;

  localparam int IL = 4;
  localparam int FL = 16;
  localparam int DW = IL + FL;

  typedef logic [DW-1:0] fx_t;

  // Window element positions inside the 2x2 window array
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

endpackage

// File: rtl/pool_line_buffer.sv
// One-row line buffer: holds the even row of a 2x2 window pair.
// Written during even rows, read combinationally at col-1 and col
// while the following odd row completes windows.
module pool_line_buffer #(
  parameter int DW   = 20,
  parameter int COLS = 8,
  localparam int AW  = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rd_prev_o,
  output logic [DW-1:0] rd_cur_o
);

  logic [DW-1:0] mem_q [COLS];
  logic [AW-1:0] prev_addr;

  // Clamp at column 0 so the address never leaves the array; the prev
  // port is only consumed at odd columns, where col-1 is always valid.
  always_comb begin
    prev_addr = '0;
    if (raddr_i != '0) prev_addr = raddr_i - 1'b1;
  end

  // Storage write; intentionally not reset, every entry is written
  // before it is read within a frame.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rd_prev_o = mem_q[prev_addr];
  assign rd_cur_o  = mem_q[raddr_i];

endmodule

// File: rtl/pool_window_gen.sv
// Assembles non-overlapping 2x2 stride-2 windows from a row-major
// activation stream. The even row goes into the line buffer, the odd
// row's even-column element is parked in `left`, and the odd-column
// element completes a window that is registered with a one-cycle pulse.
//
// Handshake: an element transfers on any rising edge where
// in_valid & in_ready. in_ready only depends on en, pool_ready and the
// current stream position (never on in_valid); only the completing
// element of a window waits for pool_ready.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int IL   = pool_pkg::IL,
  parameter int FL   = pool_pkg::FL,
  parameter int COLS = 8,
  parameter int ROWS = 8,
  localparam int DW  = IL + FL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  input  logic                pool_ready,
  output logic [3:0][DW-1:0]  win,
  output logic                win_ready,
  output logic                frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [DW-1:0]        left_q, left_d;
  logic [3:0][DW-1:0]   win_q, win_d;
  logic                 win_ready_q, win_ready_d;
  logic                 frame_done_q, frame_done_d;

  logic                 odd_row, odd_col, completing, frame_last;
  logic                 accept, line_we;
  logic [DW-1:0]        line_prev, line_cur;

  assign odd_row    = row_q[0];
  assign odd_col    = col_q[0];
  assign completing = odd_row & odd_col;
  assign frame_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign in_ready   = en & (pool_ready | ~completing);
  assign accept     = in_valid & in_ready;
  assign line_we    = accept & ~odd_row;

  pool_line_buffer #(
    .DW   (DW),
    .COLS (COLS)
  ) u_line (
    .clk       (clk),
    .we_i      (line_we),
    .waddr_i   (col_q),
    .wdata_i   (in_data),
    .raddr_i   (col_q),
    .rd_prev_o (line_prev),
    .rd_cur_o  (line_cur)
  );

  // Next-state: advance position, capture left element, build window
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    left_d       = left_q;
    win_d        = win_q;
    win_ready_d  = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (odd_row && !odd_col) left_d = in_data;
      if (completing) begin
        win_d[TL]    = line_prev;
        win_d[TR]    = line_cur;
        win_d[BL]    = left_q;
        win_d[BR]    = in_data;
        win_ready_d  = 1'b1;
        frame_done_d = frame_last;
      end
    end
  end

  // State registers; reset drops any partial window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      win_q        <= '0;
      win_ready_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      left_q       <= left_d;
      win_q        <= win_d;
      win_ready_q  <= win_ready_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win        = win_q;
  assign win_ready  = win_ready_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen on a 4x4 map: directed scenarios plus
// randomized data / en / pool_ready, checked against a window model
// computed from frame pixel indices.
module tb_pool_window_gen;
  import pool_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int NPIX = COLS * ROWS;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic               en, in_valid, in_ready, pool_ready;
  logic [DW-1:0]      in_data;
  logic [3:0][DW-1:0] win;
  logic               win_ready, frame_done;

  pool_window_gen #(
    .IL   (IL),
    .FL   (FL),
    .COLS (COLS),
    .ROWS (ROWS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pool_ready (pool_ready),
    .win        (win),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  // ---------------- bookkeeping ----------------
  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int frame_pos = 0;
  int n_fd      = 0;
  int n_stray   = 0;

  logic [4*DW-1:0] exp_q[$];
  logic [4*DW-1:0] got_q[$];
  int              exp_cyc_q[$];
  int              got_cyc_q[$];
  bit              exp_fd_q[$];
  bit              got_fd_q[$];
  logic [DW-1:0]   val_q[$];
  int              acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every window pulse with the cycle it was seen in
  always @(negedge clk) begin
    if (win_ready === 1'b1) begin
      got_q.push_back(win);
      got_cyc_q.push_back(cyc);
      got_fd_q.push_back(frame_done === 1'b1);
      if (frame_done === 1'b1) n_fd++;
    end else if (rst_n === 1'b1 && frame_done !== 1'b0) begin
      n_stray++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Consume n accepted elements (from the start of a frame) and list the
  // windows they complete: window (wr,wc) is done by the element at
  // row 2wr+1, col 2wc+1 and shows up the cycle after it was accepted.
  task automatic model_frame(input int n);
    logic [DW-1:0] v[$];
    int            a[$];
    int            tl, tr, bl, br;
    for (int i = 0; i < n; i++) begin
      v.push_back(val_q.pop_front());
      a.push_back(acc_q.pop_front());
    end
    for (int wr = 0; wr < ROWS / 2; wr++) begin
      for (int wc = 0; wc < COLS / 2; wc++) begin
        tl = 2 * wr * COLS + 2 * wc;
        tr = tl + 1;
        bl = tl + COLS;
        br = bl + 1;
        if (br < n) begin
          exp_q.push_back({v[br], v[bl], v[tr], v[tl]});
          exp_cyc_q.push_back(a[br] + 1);
          exp_fd_q.push_back(br == NPIX - 1);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Present one element and hold it until it is accepted. Directed mode
  // holds pool_ready / en low for the first stall_pr / stall_en cycles;
  // random mode draws both every cycle.
  task automatic send(input logic [DW-1:0] v, input bit rnd,
                      input int stall_pr, input int stall_en,
                      output int waited);
    int   n;
    bit   comp, done, accepted;
    logic exp_rdy;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    n        = 0;
    done     = 1'b0;
    accepted = 1'b0;
    while (!done) begin
      if (rnd) begin
        en         = ($urandom_range(0, 3) != 0);
        pool_ready = ($urandom_range(0, 2) != 0);
      end else begin
        en         = (n >= stall_en);
        pool_ready = (n >= stall_pr);
      end
      #1;
      comp    = (((frame_pos / COLS) % 2) == 1) && (((frame_pos % COLS) % 2) == 1);
      exp_rdy = en & (pool_ready | ~comp);
      n_vec++;
      assert (in_ready === exp_rdy) else begin
        n_err++;
        $error("FAIL in_ready[pos %0d]: got %b, expected %b", frame_pos, in_ready, exp_rdy);
      end
      if (n > 0) begin
        n_vec++;
        assert (win_ready === 1'b0 && frame_done === 1'b0) else begin
          n_err++;
          $error("FAIL stall_pulse[pos %0d]: got %b%b, expected 00", frame_pos, win_ready, frame_done);
        end
      end
      if (in_ready === 1'b1) begin
        done     = 1'b1;
        accepted = 1'b1;
      end else if (n >= 200) begin
        n_err++;
        $error("FAIL accept_timeout[pos %0d]: got no accept, expected accept within 200 cycles", frame_pos);
        done = 1'b1;
      end else begin
        n++;
        @(negedge clk);
      end
    end
    waited = n;
    if (accepted) begin
      val_q.push_back(v);
      acc_q.push_back(cyc);
      frame_pos = (frame_pos + 1) % NPIX;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid   = 1'b0;
    en         = 1'b1;
    pool_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_results(input string tag);
    logic [4*DW-1:0] e, g;
    int              ec, gc;
    bit              ef, gf;
    n_vec++;
    assert (got_q.size() === exp_q.size()) else begin
      n_err++;
      $error("FAIL %s_count: got %0d windows, expected %0d", tag, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e  = exp_q.pop_front();      g  = got_q.pop_front();
      ec = exp_cyc_q.pop_front();  gc = got_cyc_q.pop_front();
      ef = exp_fd_q.pop_front();   gf = got_fd_q.pop_front();
      n_vec++;
      assert (g === e) else begin
        n_err++;
        $error("FAIL %s_win: got %h, expected %h", tag, g, e);
      end
      n_vec++;
      assert (gc === ec) else begin
        n_err++;
        $error("FAIL %s_latency: got cycle %0d, expected cycle %0d", tag, gc, ec);
      end
      n_vec++;
      assert (gf === ef) else begin
        n_err++;
        $error("FAIL %s_frame_done: got %b, expected %b", tag, gf, ef);
      end
    end
    n_vec++;
    assert (n_stray === 0) else begin
      n_err++;
      $error("FAIL %s_stray_frame_done: got %0d, expected 0", tag, n_stray);
    end
    exp_q.delete();  got_q.delete();
    exp_cyc_q.delete();  got_cyc_q.delete();
    exp_fd_q.delete();   got_fd_q.delete();
    n_stray = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            w;
    logic [31:0]   r32;
    logic [DW-1:0] fv;

    rst_n      = 1'b1;
    en         = 1'b1;
    pool_ready = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    #1 rst_n   = 1'b0;
    #2;
    n_vec++;
    assert (win === '0 && win_ready === 1'b0 && frame_done === 1'b0) else begin
      n_err++;
      $error("FAIL reset_outputs: got %h/%b/%b, expected 0/0/0", win, win_ready, frame_done);
    end
    n_vec++;
    assert (in_ready === 1'b1) else begin
      n_err++;
      $error("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Continuous 1..16 frame
    for (int i = 1; i <= NPIX; i++) send(DW'(i), 1'b0, 0, 0, w);
    idle(2);
    model_frame(NPIX);
    check_results("continuous");

    // pool_ready held low while element 6 is presented
    for (int i = 1; i <= 5; i++) begin
      send(DW'(i), 1'b0, 0, 0, w);
      n_vec++;
      assert (w === 0) else begin
        n_err++;
        $error("FAIL no_stall_%0d: got %0d wait cycles, expected 0", i, w);
      end
    end
    send(DW'(6), 1'b0, 3, 0, w);
    n_vec++;
    assert (w === 3) else begin
      n_err++;
      $error("FAIL pool_stall_wait: got %0d wait cycles, expected 3", w);
    end
    for (int i = 7; i <= NPIX; i++) send(DW'(i), 1'b0, 0, 0, w);
    idle(2);
    model_frame(NPIX);
    check_results("pool_stall");

    // en dropped for 3 cycles after element 3
    for (int i = 1; i <= 3; i++) send(DW'(i), 1'b0, 0, 0, w);
    send(DW'(4), 1'b0, 0, 3, w);
    n_vec++;
    assert (w === 3) else begin
      n_err++;
      $error("FAIL en_gap_wait: got %0d wait cycles, expected 3", w);
    end
    for (int i = 5; i <= NPIX; i++) send(DW'(i), 1'b0, 0, 0, w);
    idle(2);
    model_frame(NPIX);
    check_results("en_gap");

    // Asynchronous reset after element 7, then a full restream
    for (int i = 1; i <= 7; i++) send(DW'(i), 1'b0, 0, 0, w);
    idle(2);
    model_frame(7);
    check_results("pre_reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    assert (win === '0 && win_ready === 1'b0 && frame_done === 1'b0) else begin
      n_err++;
      $error("FAIL async_reset: got %h/%b/%b, expected 0/0/0", win, win_ready, frame_done);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    frame_pos = 0;
    for (int i = 1; i <= NPIX; i++) send(DW'(i), 1'b0, 0, 0, w);
    idle(2);
    model_frame(NPIX);
    check_results("after_reset");

    // Two back-to-back fixed-point frames
    n_fd = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        r32 = $urandom;
        fv  = r32[DW-1:0];
        if (i == 0) fv = DW'(520);
        if (i == 1) fv = DW'(360);
        if (i == 4) fv = DW'(1378);
        if (i == 5) fv = DW'(280);
        send(fv, 1'b0, 0, 0, w);
      end
    end
    idle(2);
    model_frame(NPIX);
    model_frame(NPIX);
    n_vec++;
    assert (n_fd === 2) else begin
      n_err++;
      $error("FAIL two_frame_done_count: got %0d, expected 2", n_fd);
    end
    check_results("fixed_point");

    // Random data with random en / pool_ready over two frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        r32 = $urandom;
        fv  = r32[DW-1:0];
        send(fv, 1'b1, 0, 0, w);
      end
    end
    idle(2);
    model_frame(NPIX);
    model_frame(NPIX);
    check_results("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
